// File: rtl/tt_um_counter_checker.sv
// ============================================================================
// Module   : tt_um_counter_checker
// Purpose  : Locks onto a strobed incrementing 8-bit stream and counts
//            sequence errors. Optional idle timeout: CHK_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tt_um_counter_checker #(
    parameter int LOCK_LEN = 2,
    parameter int LOSS_LEN = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);
    localparam logic [3:0] LOSS_N = 4'(LOSS_LEN);

    logic       strobe, resync, sel, clear;
    logic [7:0] s_inc;

    assign strobe = uio_in[0];
    assign resync = uio_in[1];
    assign sel    = uio_in[2];
    assign clear  = uio_in[3];
    assign s_inc  = ui_in + 8'd1;

    state_t     state_q, state_d;
    logic [7:0] exp_q, exp_d;
    logic [3:0] match_q, match_d;
    logic [3:0] miss_q, miss_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       sticky_q, sticky_d;
    logic       pulse_q, pulse_d;
    logic       tflag_q;

`ifdef CHK_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT);
    logic [15:0] idle_q, idle_d;
    logic        tflag_d;
`endif

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_cnt_d = err_cnt_q;
        sticky_d  = sticky_q;
        pulse_d   = 1'b0;
`ifdef CHK_TIMEOUT_EN
        idle_d    = idle_q;
        tflag_d   = tflag_q;
`endif
        if (resync) begin
            state_d = HUNT;
            match_d = 4'd0;
            miss_d  = 4'd0;
`ifdef CHK_TIMEOUT_EN
            idle_d  = 16'd0;
`endif
        end else begin
            if (clear) begin
                err_cnt_d = 8'd0;
                sticky_d  = 1'b0;
`ifdef CHK_TIMEOUT_EN
                tflag_d   = 1'b0;
`endif
            end
            if (strobe) begin
                exp_d = s_inc;
                case (state_q)
                    HUNT: begin
                        match_d = 4'd0;
                        state_d = CONFIRM;
                    end
                    CONFIRM: begin
                        if (ui_in == exp_q) begin
                            if (match_q + 4'd1 == LOCK_N) begin
                                state_d = LOCKED;
                                match_d = 4'd0;
                            end else begin
                                match_d = match_q + 4'd1;
                            end
                        end else begin
                            match_d = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (ui_in == exp_q) begin
                            miss_d = 4'd0;
                        end else begin
                            pulse_d = 1'b1;
                            // a concurrent clear keeps count and sticky at zero
                            if (!clear) begin
                                sticky_d = 1'b1;
                                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                            end
                            if (miss_q + 4'd1 == LOSS_N) begin
                                state_d = HUNT;
                                miss_d  = 4'd0;
                            end else begin
                                miss_d = miss_q + 4'd1;
                            end
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
`ifdef CHK_TIMEOUT_EN
            if (state_q == HUNT || strobe) begin
                idle_d = 16'd0;
            end else if (idle_q + 16'd1 == TIMEOUT_N) begin
                state_d = HUNT;
                match_d = 4'd0;
                miss_d  = 4'd0;
                tflag_d = 1'b1;
                idle_d  = 16'd0;
            end else begin
                idle_d = idle_q + 16'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            exp_q     <= 8'h00;
            match_q   <= 4'd0;
            miss_q    <= 4'd0;
            err_cnt_q <= 8'd0;
            sticky_q  <= 1'b0;
            pulse_q   <= 1'b0;
`ifdef CHK_TIMEOUT_EN
            idle_q    <= 16'd0;
            tflag_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_cnt_q <= err_cnt_d;
            sticky_q  <= sticky_d;
            pulse_q   <= pulse_d;
`ifdef CHK_TIMEOUT_EN
            idle_q    <= idle_d;
            tflag_q   <= tflag_d;
`endif
        end
    end

`ifndef CHK_TIMEOUT_EN
    assign tflag_q = 1'b0;
`endif

    assign uo_out  = sel ? exp_q : err_cnt_q;
    assign uio_out = {(err_cnt_q == 8'hFF), sticky_q, pulse_q,
                      (state_q == LOCKED), tflag_q, 3'b000};
    assign uio_oe  = 8'hF0;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4], (TIMEOUT != 0)};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_counter_checker.sv
// Directed bench for tt_um_counter_checker (LOCK_LEN=2, LOSS_LEN=2, TIMEOUT=8).
`default_nettype none

module tb_tt_um_counter_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic       strobe = 1'b0, resync = 1'b0, sel = 1'b0, clr = 1'b0;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int passed = 0;
    int total  = 0;
    logic [7:0] e;

    assign uio_in = {4'b0000, clr, sel, resync, strobe};

    always #5 clk = ~clk;

    tt_um_counter_checker #(
        .LOCK_LEN(2),
        .LOSS_LEN(2),
        .TIMEOUT (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
        total++;
        assert (obs === req) passed++;
        else $error("FAIL %s: observed %02h required %02h", tag, obs, req);
    endtask

    task automatic sample(input logic [7:0] v);
        ui_in  = v;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_exp(input string tag, input logic [7:0] req);
        sel = 1'b1;
        #1;
        check(tag, uo_out, req);
        sel = 1'b0;
        #1;
    endtask

    task automatic do_resync();
        resync = 1'b1;
        @(posedge clk);
        #1;
        resync = 1'b0;
    endtask

    initial begin
        // reset state
        idle(2);
        rst = 1'b0;
        #1;
        check("reset_uo_cnt", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hF0);
        check_exp("reset_expected", 8'h00);

        // lock on 3C,3D,3E
        sample(8'h3C);
        check("lock_after1", {7'd0, uio_out[4]}, 8'h00);
        sample(8'h3D);
        check("lock_after2", {7'd0, uio_out[4]}, 8'h00);
        sample(8'h3E);
        check("lock_after3", {7'd0, uio_out[4]}, 8'h01);
        check_exp("lock_expected", 8'h3F);
        check("lock_errcnt", uo_out, 8'h00);

        // resync drops lock, then wrap through FF->00
        do_resync();
        check("resync_unlocked", {7'd0, uio_out[4]}, 8'h00);
        sample(8'hFB); sample(8'hFC); sample(8'hFD);
        check("wrap_locked", uio_out, 8'h10);
        sample(8'hFE);
        check("wrap_fe", uio_out, 8'h10);
        sample(8'hFF);
        check("wrap_ff", uio_out, 8'h10);
        sample(8'h00);
        check("wrap_00", uio_out, 8'h10);
        sample(8'h01);
        check("wrap_01", uio_out, 8'h10);
        check_exp("wrap_expected", 8'h02);

        // single error at expected 0x10
        do_resync();
        sample(8'h0D); sample(8'h0E); sample(8'h0F);
        check_exp("single_pre_expected", 8'h10);
        sample(8'h55);
        check("single_pulse", uio_out, 8'h70);
        sample(8'h56);
        check("single_after", uio_out, 8'h50);
        check("single_errcnt", uo_out, 8'h01);
        check_exp("single_expected", 8'h57);

        // loss of lock after two consecutive misses
        sample(8'h20);
        check("loss_first", uio_out, 8'h70);
        sample(8'h80);
        check("loss_second", uio_out, 8'h60);
        check("loss_errcnt", uo_out, 8'h03);
        sample(8'h81); sample(8'h82);
        check("relock_pending", {7'd0, uio_out[4]}, 8'h00);
        sample(8'h83);
        check("relock", uio_out, 8'h50);
        check_exp("relock_expected", 8'h84);

        // saturation: 300 isolated mismatches, each realigned by a match
        e = 8'h84;
        for (int i = 0; i < 300; i++) begin
            sample(e + 8'h40);
            e = e + 8'h41;
            sample(e);
            e = e + 8'h01;
        end
        check("sat_errcnt", uo_out, 8'hFF);
        check("sat_flags", uio_out, 8'hD0);
        check_exp("sat_expected", e);

        // clear together with a mismatch
        clr = 1'b1;
        sample(e + 8'h40);
        clr = 1'b0;
        e = e + 8'h41;
        check("clear_flags", uio_out, 8'h30);
        check("clear_errcnt", uo_out, 8'h00);
        check_exp("clear_expected", e);
        sample(e);
        e = e + 8'h01;
        check("clear_next", uio_out, 8'h10);

        // idle period
        idle(7);
        check("idle7_locked", {7'd0, uio_out[4]}, 8'h01);
        idle(1);
`ifdef CHK_TIMEOUT_EN
        check("idle8_timeout", uio_out, 8'h08);
`else
        check("idle8_held", uio_out, 8'h10);
`endif

        // mid-stream reset
        sample(8'h10);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_mid_uio", uio_out, 8'h00);
        check("rst_mid_cnt", uo_out, 8'h00);
        check_exp("rst_mid_expected", 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
